// File: rtl/demux1to4_hs_if.sv
// demux1to4_hs_if: producer-side and four consumer-side handshakes of the 1-to-4 demux.
interface demux1to4_hs_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] in_data;
  logic [1:0] in_sel;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [2:0] occupancy;
  modport slave (
    input in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data0, out_data1, out_data2, out_data3, out_valid, occupancy
  );
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input in_ready, out_data0, out_data1, out_data2, out_data3, out_valid, occupancy
  );
endinterface

// File: rtl/demux1to4_hs.sv
// demux1to4_hs: steers one word per cycle into one of four single-entry slots that drain independently.
module demux1to4_hs #(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset,
  demux1to4_hs_if.slave bus
);
  logic [WIDTH-1:0] data [4];
  logic [3:0] full;
  logic [3:0] load;
  logic [3:0] drain;
  logic ready;
  // readiness looks only at the selected slot, so a full slot never blocks the others
  always_comb begin
    ready = ~reset & (~full[bus.in_sel] | bus.out_ready[bus.in_sel]);
    load = (bus.in_valid & ready) ? 4'b0001 << bus.in_sel : 4'b0000;
    drain = full & bus.out_ready;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      full <= '0;
      for (int i = 0; i < 4; i++) data[i] <= '0;
    end else begin
      full <= load | (full & ~drain);
      for (int i = 0; i < 4; i++) if (load[i]) data[i] <= bus.in_data;
    end
  assign bus.in_ready = ready;
  assign bus.out_data0 = data[0];
  assign bus.out_data1 = data[1];
  assign bus.out_data2 = data[2];
  assign bus.out_data3 = data[3];
  assign bus.out_valid = full;
  assign bus.occupancy = 3'(full[0]) + 3'(full[1]) + 3'(full[2]) + 3'(full[3]);
endmodule

// File: tb/tb_demux1to4_hs.sv
// tb_demux1to4_hs: per-slot expected-word queues fed by the driver, popped and compared by a monitor.
module tb_demux1to4_hs;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];
  logic [31:0] q3 [$];
  logic [3:0] drain_exp = '0;
  demux1to4_hs_if #(.WIDTH(32)) bus ();
  demux1to4_hs #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return i == 0 ? q0.size() : i == 1 ? q1.size() : i == 2 ? q2.size() : q3.size();
  endfunction

  function automatic logic [31:0] qfront(input int i);
    return i == 0 ? q0[0] : i == 1 ? q1[0] : i == 2 ? q2[0] : q3[0];
  endfunction

  function automatic logic [31:0] dout(input int i);
    return i == 0 ? bus.out_data0 : i == 1 ? bus.out_data1 : i == 2 ? bus.out_data2 : bus.out_data3;
  endfunction

  task automatic qpush(input int i, input logic [31:0] d);
    if (i == 0) q0.push_back(d);
    else if (i == 1) q1.push_back(d);
    else if (i == 2) q2.push_back(d);
    else q3.push_back(d);
  endtask

  task automatic qpop(input int i);
    if (i == 0) void'(q0.pop_front());
    else if (i == 1) void'(q1.pop_front());
    else if (i == 2) void'(q2.pop_front());
    else void'(q3.pop_front());
  endtask

  // one producer/consumer cycle; the expected word is queued once the accept decision is final
  task automatic cycle(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
    @(posedge clk);
    #2;
    bus.in_valid = v;
    bus.in_sel = s;
    bus.in_data = d;
    bus.out_ready = r;
    @(negedge clk);
    #1;
    if (v && (qsize(int'(s)) == 0 || r[s])) qpush(int'(s), d);
  endtask

  initial forever begin
    int occ;
    @(posedge clk);
    #1;
    if (!reset) begin
      for (int i = 0; i < 4; i++) if (drain_exp[i]) qpop(i);
      occ = 0;
      for (int i = 0; i < 4; i++) begin
        occ += qsize(i);
        chk($sformatf("out_valid[%0d]", i), 32'(bus.out_valid[i]), 32'(qsize(i) != 0));
        if (qsize(i) != 0) chk($sformatf("out_data%0d", i), dout(i), qfront(i));
      end
      chk("occupancy", 32'(bus.occupancy), 32'(occ));
    end
    drain_exp = '0;
    @(negedge clk);
    if (!reset) begin
      chk("in_ready", 32'(bus.in_ready),
          32'(qsize(int'(bus.in_sel)) == 0 || bus.out_ready[bus.in_sel]));
      for (int i = 0; i < 4; i++) drain_exp[i] = qsize(i) != 0 && bus.out_ready[i];
    end
  end

  initial begin
    bus.in_valid = 1'b1;
    bus.in_sel = 2'd0;
    bus.in_data = '0;
    bus.out_ready = 4'hF;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    cycle(1'b1, 2'd1, 32'hDEADBEEF, 4'b0000);
    cycle(1'b0, 2'd1, 32'h0, 4'b0000);
    chk("route_valid", 32'(bus.out_valid), 32'h2);
    chk("route_data1", bus.out_data1, 32'hDEADBEEF);
    chk("route_ready_sel1", 32'(bus.in_ready), 32'd0);
    bus.in_sel = 2'd3;
    #1;
    chk("route_ready_sel3", 32'(bus.in_ready), 32'd1);
    cycle(1'b0, 2'd0, 32'h0, 4'b0010);
    for (int s = 0; s < 4; s++) cycle(1'b1, 2'(s), 32'h11 * (s + 1), 4'b0000);
    for (int s = 0; s < 4; s++) cycle(1'b0, 2'(s), 32'h0, 4'b0000);
    chk("fill_occupancy", 32'(bus.occupancy), 32'd4);
    cycle(1'b0, 2'd0, 32'h0, 4'hF);
    cycle(1'b1, 2'd3, 32'hA5, 4'b0000);
    cycle(1'b1, 2'd3, 32'h5A, 4'b1000);
    cycle(1'b0, 2'd3, 32'h0, 4'b0000);
    chk("pass_data3", bus.out_data3, 32'h5A);
    chk("pass_occupancy", 32'(bus.occupancy), 32'd1);
    cycle(1'b0, 2'd0, 32'h0, 4'hF);
    for (int k = 0; k < 8; k++) cycle(1'b1, 2'd0, 32'(k), 4'b0001);
    cycle(1'b0, 2'd0, 32'h0, 4'b0001);
    cycle(1'b1, 2'd0, 32'h100, 4'b0000);
    cycle(1'b1, 2'd2, 32'h102, 4'b0000);
    cycle(1'b1, 2'd1, 32'h101, 4'b0101);
    cycle(1'b0, 2'd0, 32'h0, 4'b0000);
    chk("mixed_valid", 32'(bus.out_valid), 32'h2);
    chk("mixed_occupancy", 32'(bus.occupancy), 32'd1);
    cycle(1'b1, 2'd2, 32'hC0FFEE, 4'b0000);
    cycle(1'b0, 2'd2, 32'h0, 4'b0000);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_occupancy", 32'(bus.occupancy), 32'd0);
    chk("midrst_data2", bus.out_data2, 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    q0.delete();
    q1.delete();
    q2.delete();
    q3.delete();
    repeat (2) @(posedge clk);
    #2;
    chk("midrst_in_ready_hold", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    repeat (3000) cycle($urandom_range(0, 99) < 70, 2'($urandom), $urandom, 4'($urandom));
    cycle(1'b0, 2'd0, 32'h0, 4'hF);
    cycle(1'b0, 2'd0, 32'h0, 4'h0);
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux1to4_hs.md
# demux1to4_hs

Registered 1-to-4 demultiplexer with valid/ready handshakes; the write-side counterpart of the generic 4-to-1 select muxes. A single producer (e.g. the ALU/memory result path) presents one word plus a 2-bit destination select, and the block steers it into one of four single-entry holding slots. Each slot drains independently to its consumer. Used wherever one result must be delivered to one of four sinks without stalling the other three.

## Interface
- WIDTH, 32, data width of input and of each output slot
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_data  input  WIDTH  word to route
- in_sel  input  2  destination slot: 2'b00 → 0, 2'b01 → 1, 2'b10 → 2, 2'b11 → 3
- in_valid  input  1  producer has a word
- in_ready  output  1  block can accept a word for the current in_sel
- out_data0..out_data3  output  WIDTH each  slot contents, registered
- out_valid  output  4  bit i = slot i holds a word
- out_ready  input  4  bit i = consumer i takes slot i this cycle
- occupancy  output  3  number of full slots, 0..4

## Operation
- State per slot i: data_i (WIDTH), full_i (1 bit). out_data_i = data_i; out_valid[i] = full_i; occupancy = popcount(full).
- Combinational: in_ready = ~reset & (~full[in_sel] | out_ready[in_sel]). Depends only on in_sel and the selected slot. Other slots' state has no effect.
- accept = in_valid & in_ready; load_i = accept & (in_sel == i); drain_i = full_i & out_ready[i].
- Per slot, each clock edge:
  - load_i=1: data_i ← in_data, full_i ← 1, whether or not drain_i is also 1. Simultaneous drain+load is pass-through: the old word leaves and the new word lands the same edge.
  - load_i=0, drain_i=1: full_i ← 0. data_i holds its old value.
  - Neither: hold.
- out_ready[i] while full_i=0 has no effect.
- in_data and in_sel are ignored when accept=0.
- Words to different slots never reorder relative to their own slot. Slots are fully independent.
- At most one slot loads per cycle. Any number of slots may drain in the same cycle.

## Timing
- Reset: while asserted and after release, full=4'b0000, all data_i=0, occupancy=0, in_ready=0 while reset=1.
- Reset mid-transfer discards all held words. No output pulse is generated.
- Latency: a word accepted at edge N appears on out_data_i/out_valid[i] after edge N and is stable until the edge where drain_i=1.
- Throughput: one word per cycle into any slot whose consumer holds out_ready high, including back-to-back words to the same slot.
- Full slot with out_ready low: in_ready=0 for that in_sel only. The producer may change in_sel to reach a non-full slot. Its own protocol determines whether that is allowed.
- occupancy updates on the same edge as full. Simultaneous load of slot a and drain of slot b≠a leaves occupancy unchanged.

## Test plan
- Reset then idle: assert reset mid-cycle with slot 2 full → out_valid=0000, occupancy=0, out_data2=0 immediately, in_ready=0 until reset=0.
- Single route: in_sel=2'b01, in_data=32'hDEADBEEF, in_valid=1, out_ready=0000 → after one edge out_valid=0010, out_data1=DEADBEEF, occupancy=1. Next cycle with in_sel=01, in_ready=0. With in_sel=11, in_ready=1.
- Fill all four: send 0x11, 0x22, 0x33, 0x44 to slots 0..3 with out_ready=0000 → out_valid=1111, occupancy=4, in_ready=0 for every in_sel.
- Pass-through: slot 3 full with 0xA5, out_ready=1000, in_sel=11, in_data=0x5A, in_valid=1 → in_ready=1; after edge out_valid[3]=1, out_data3=0x5A, occupancy unchanged.
- Streaming: 8 consecutive words 0..7 to slot 0 with out_ready[0]=1 → accepted one per cycle, consumer sees 0..7 in order with no gaps.
- Mixed drain: slots 0 and 2 full, out_ready=0101, simultaneous load to slot 1 → after edge out_valid=0010, occupancy goes from 2 to 1.
